// File: rtl/board_port_arbiter.sv
// Round-robin arbiter sharing one board_mem control port among N_REQ requesters,
// with a built-in sequencer that zero-fills the X_SIZE x Y_SIZE board.
module board_port_arbiter #(
  parameter int unsigned N_REQ      = 3,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned X_SIZE     = 12,
  parameter int unsigned Y_SIZE     = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_w_nr,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]       rdata,
  input  logic                        clear_start,
  output logic                        clear_done,
  output logic                        busy,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic                        mem_w_nr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SumW = PtrW + 1;
  localparam int unsigned CntW = ADDR_WIDTH / 2;

  localparam logic [CntW-1:0] XLast   = CntW'(X_SIZE - 1);
  localparam logic [CntW-1:0] YLast   = CntW'(Y_SIZE - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(N_REQ - 1);
  localparam logic [SumW-1:0] NReqS   = SumW'(N_REQ);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone,
    StClear
  } state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]       grant_q, grant_d;
  logic                  wr_q, wr_d;
  logic                  pend_q, pend_d;
  logic [CntW-1:0]       x_q, x_d;
  logic [CntW-1:0]       y_q, y_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  clear_done_q, clear_done_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_w_nr_q, mem_w_nr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Winner: first set request scanning upward from rr_ptr, wrapping at N_REQ.
  logic            found;
  logic [PtrW-1:0] win;
  logic [SumW-1:0] cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + SumW'(i);
      if (cand >= NReqS) begin
        cand = cand - NReqS;
      end
      if (!found && req[cand[PtrW-1:0]]) begin
        found = 1'b1;
        win   = cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    pend_d       = pend_q | (clear_start & (state_q != StClear));
    x_d          = x_q;
    y_d          = y_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    clear_done_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_w_nr_d   = 1'b0;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (pend_q || clear_start) begin
          // First clear write is presented in the very first CLEAR cycle.
          state_d     = StClear;
          pend_d      = 1'b0;
          x_d         = '0;
          y_d         = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_w_nr_d  = 1'b1;
        end else if (found) begin
          state_d     = StAccess;
          grant_d     = win;
          wr_d        = req_w_nr[win];
          mem_addr_d  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
          mem_w_nr_d  = req_w_nr[win];
        end
      end
      StAccess: begin
        state_d = StDone;
      end
      StDone: begin
        state_d        = StIdle;
        ack_d[grant_q] = 1'b1;
        if (!wr_q) begin
          rdata_d = mem_rdata;
        end
        rr_ptr_d = (grant_q == PtrLast) ? '0 : grant_q + 1'b1;
      end
      StClear: begin
        mem_wdata_d = '0;
        if (x_q == XLast && y_q == YLast) begin
          state_d      = StIdle;
          clear_done_d = 1'b1;
          x_d          = '0;
          y_d          = '0;
        end else begin
          if (x_q == XLast) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          mem_addr_d = ADDR_WIDTH'({y_d, x_d});
          mem_w_nr_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      wr_q         <= 1'b0;
      pend_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_nr_q   <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      pend_q       <= pend_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      clear_done_q <= clear_done_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_nr_q   <= mem_w_nr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign clear_done = clear_done_q;
  assign busy       = busy_q;
  assign mem_addr   = mem_addr_q;
  assign mem_w_nr   = mem_w_nr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
